// File: rtl/pwm_decimator.sv
// rtl/pwm_decimator.sv - boxcar decimator recovering signed PCM samples from a 1-bit pulse-density stream
module pwm_decimator #(
   parameter int WIDTH    = 8,
   parameter int LOG2_LEN = 8
) (
   input  logic             clk,
   input  logic             rst_an,
   input  logic             din,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun
);

   // LOG2_LEN must be >= WIDTH so the window total can be truncated to WIDTH+1 bits.
   localparam int SHIFT = LOG2_LEN - WIDTH;

   localparam logic [LOG2_LEN-1:0] WCNT_LAST = {LOG2_LEN{1'b1}};
   localparam logic [LOG2_LEN-1:0] WCNT_ONE  = {{(LOG2_LEN-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]    SAMPLE_MAX = {1'b0, {(WIDTH-1){1'b1}}};

   logic [LOG2_LEN-1:0] wcnt_q, wcnt_d;
   logic [LOG2_LEN:0]   acc_q, acc_d;
   logic [WIDTH-1:0]    dout_q, dout_d;
   logic                valid_q, valid_d;
   logic                overrun_q, overrun_d;

   logic                win_end;
   logic [LOG2_LEN:0]   total;
   logic [LOG2_LEN:0]   scaled;
   logic [WIDTH-1:0]    sample;

   // Window total including the bit sampled on this edge, then truncated and offset to signed.
   always_comb begin
      total  = acc_q + {{LOG2_LEN{1'b0}}, din};
      scaled = total >> SHIFT;
      // Any bit at or above WIDTH means scaled reached 2^WIDTH (all ones): clamp to max positive.
      // Otherwise subtracting 2^(WIDTH-1) is just flipping the top bit.
      if (|scaled[LOG2_LEN:WIDTH]) begin
         sample = SAMPLE_MAX;
      end else begin
         sample = {~scaled[WIDTH-1], scaled[WIDTH-2:0]};
      end
   end

   // A sample is produced only on the last slot of the window, and restart strobe beats it.
   assign win_end = !sync && (wcnt_q == WCNT_LAST);

   // Next-state for the window counter, accumulator and output handshake.
   always_comb begin
      wcnt_d    = wcnt_q;
      acc_d     = acc_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      if (sync) begin
         // Restart discards this edge's din; output side is left alone.
         wcnt_d = '0;
         acc_d  = '0;
      end else if (win_end) begin
         wcnt_d = '0;
         acc_d  = '0;
      end else begin
         wcnt_d = wcnt_q + WCNT_ONE;
         acc_d  = total;
      end

      // Consumer acceptance; a coinciding window end reloads below and keeps valid high.
      if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end

      if (win_end) begin
         dout_d  = sample;
         valid_d = 1'b1;
         // Overwriting a sample that nobody took is latched until reset.
         if (valid_q && !dout_ready) begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers; asynchronous reset drops any partial window.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         wcnt_q    <= '0;
         acc_q     <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         wcnt_q    <= wcnt_d;
         acc_q     <= acc_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign overrun    = overrun_q;

endmodule

// File: doc/pwm_decimator.md
Name: pwm_decimator

Overview:
- Receive-side counterpart of the PWM/sigma-delta DAC.
- Recovers signed 8-bit PCM samples from a 1-bit pulse-density stream by counting ones over a fixed window of 2^LOG2_LEN clocks (boxcar decimation).
- Sits on the analysis/loopback path and hands samples to a consumer through a valid/ready handshake.
- Used for DAC loopback checks and for capturing 1-bit modulated inputs.

Parameters:
- WIDTH, 8: output sample width in bits (signed, two's complement).
- LOG2_LEN, 8: log2 of the window length in clocks. Must satisfy LOG2_LEN >= WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_an  input  1  asynchronous, active-low reset.
- din  input  1  pulse-density bit stream, sampled every rising edge of clk.
- sync  input  1  window restart strobe; synchronous, active high.
- dout  output  WIDTH  decoded signed sample.
- dout_valid  output  1  dout holds an unconsumed sample.
- dout_ready  input  1  consumer accepts dout on a rising edge where dout_valid=1.
- overrun  output  1  sticky flag: an unconsumed sample was overwritten.

Behaviour:
- Reset (rst_an=0, asynchronous): wcnt=0, acc=0, dout=0, dout_valid=0, overrun=0. Reset may assert mid-window; the partial window is discarded. After release, a new window starts at the first rising edge.
- State:
  - wcnt: window counter, LOG2_LEN bits, counts 0..LEN-1 and wraps, where LEN = 2^LOG2_LEN.
  - acc: ones accumulator, LOG2_LEN+1 bits, range 0..LEN.
- Each rising edge with sync=0 and wcnt<LEN-1: acc <= acc+din; wcnt <= wcnt+1.
- Window end, i.e. a rising edge with sync=0 and wcnt=LEN-1:
  - total = acc+din;
  - scaled = total >> (LOG2_LEN-WIDTH);
  - s = scaled - 2^(WIDTH-1);
  - saturate s to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Only total=LEN saturates, giving +127 for the defaults.
  - dout <= s; dout_valid <= 1; acc <= 0; wcnt <= 0.
- Latency: dout and dout_valid change on the same edge that samples the last din bit of the window. One sample per LEN clocks.
- Handshake:
  - dout_valid stays high and dout stays stable until a rising edge with dout_ready=1.
  - On that edge, dout_valid clears, unless a window end occurs on the same edge.
  - dout_ready while dout_valid=0 has no effect.
- Simultaneous window end and dout_ready=1: the old sample is consumed, the new sample is loaded, dout_valid stays 1, overrun is unchanged.
- Window end while dout_valid=1 and dout_ready=0: dout is overwritten with the new sample, dout_valid stays 1, overrun <= 1. overrun is cleared only by reset.
- sync=1 at a rising edge:
  - acc <= 0; wcnt <= 0; the din of that edge is discarded and no sample is emitted.
  - sync takes priority over a coinciding window end.
  - dout, dout_valid, overrun and the handshake are unaffected.
  - Held sync keeps the window in restart.
- Arithmetic is unsigned up to the offset subtraction. No rounding: truncation by right shift.

Test Plan:
- din=0 constantly, dout_ready=1. Required: first dout_valid appears exactly 256 edges after reset release with dout=0x80 (-128); this repeats every 256 clocks.
- din=1 constantly. Required: dout=0x7F (+127, saturated); overrun stays 0 while dout_ready=1.
- din alternating 1,0 gives dout=0x00. Per window, 64 ones followed by 192 zeros gives dout=0xC0 (-64). 192 ones gives 0x40 (+64).
- dout_ready=0 across two windows with din=0 then din=1. Required: after window 1, dout_valid=1 and dout=0x80; after window 2, dout=0x7F and overrun=1. Raising dout_ready for one edge then clears dout_valid; overrun stays 1.
- Pulse sync at wcnt=100 with din=1 throughout. Required: no sample at the original boundary; the next dout_valid comes 256 edges after the sync edge, with dout=0x7F. sync at wcnt=255 suppresses that sample.
- Assert rst_an low mid-window with dout_valid=1 and overrun=1. Required: all outputs 0 immediately, without waiting for a clock edge. After release, the first sample comes after a full 256 clocks.
